vga_source_mux: RTL and testbench
=================================

// Module: vga_source_mux
// PURPOSE
//  Parametrised pixel-source selector between N video generators (colour strip, ROM image, ...) and the VGA output stage.
//  Source changes take effect only at a frame boundary, optionally after N fully blanked frames, so no frame is torn.
//  Pixel data is registered in a fixed 2-cycle pipeline; hsync/vsync/de are delayed by the same 2 cycles so they stay aligned.
// PARAMETERS
//  N_SRC         4       number of pixel sources (2..8)
//  CW            4       bits per colour channel
//  SEL_W         3       width of src_sel; must satisfy 2**SEL_W >= N_SRC
//  BLANK_FRAMES  1       whole frames forced to FILL_BLANK during a switch (0..15; 0 = switch immediately at the boundary)
//  FILL_INVALID  12'hfff {r,g,b} shown when src_sel >= N_SRC (generalised to 3*CW bits)
//  VS_ACT_LOW    1       1: in_vsync/in_hsync are active-low
// PORTS
//  clk        in   1          pixel clock (divided clock domain)
//  rst_n      in   1          synchronous active-low reset
//  src_sel    in   SEL_W      requested source index; may change at any time
//  src_rgb    in   N_SRC*3*CW source k at [k*3*CW +: 3*CW], packed {r,g,b}
//  in_hsync   in   1          timing-generator hsync
//  in_vsync   in   1          timing-generator vsync
//  in_de      in   1          visible-area flag
//  o_r/o_g/o_b out CW each    registered colour; 0 when out_de=0
//  h_sync     out  1          in_hsync delayed 2 cycles
//  v_sync     out  1          in_vsync delayed 2 cycles
//  out_de     out  1          in_de delayed 2 cycles
//  active_sel out  SEL_W      source currently displayed
//  switching  out  1          1 while in state PEND or BLANK
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - o_*=0, out_de=0, h_sync/v_sync at their inactive level, active_sel=0, pend_sel=0, switching=0.
//   - State is RUN and the frame counter is 0. Reset mid-switch abandons the switch.
//  Frame boundary (fb) is a one-cycle pulse on the cycle in_vsync first becomes active (edge detect on the registered vsync).
//  FSM:
//   - RUN:   src_sel != active_sel -> pend_sel<=src_sel, go PEND.
//   - PEND:  src_sel is re-sampled every cycle into pend_sel; the latest value wins.
//            If src_sel==active_sel before fb, return to RUN with no visible effect.
//            On fb with BLANK_FRAMES==0: active_sel<=pend_sel, go RUN.
//            On fb with BLANK_FRAMES>0: fcnt<=BLANK_FRAMES, go BLANK.
//   - BLANK: the visible area shows 0 (black). Each fb decrements fcnt.
//            On the fb where fcnt==1: active_sel<=pend_sel, go RUN; the new source is visible from that frame on.
//            src_sel changes during BLANK update pend_sel and do not restart fcnt.
//            If src_sel then equals the old active_sel, blanking still completes.
//  fb and a src_sel change on the same cycle in RUN: the change is captured into PEND and waits for the next fb.
//  Datapath:
//   - stage1 registers the active_sel source, or FILL_INVALID if active_sel >= N_SRC, or 0 in BLANK.
//     An invalid index is accepted as a legal switch target.
//   - stage2 registers stage1 ANDed with the delayed de.
//   - Latency from src_rgb/in_* to outputs is exactly 2 cycles, constant across all modes. No combinational input->output paths.
//  active_sel updates on the fb cycle itself, so the first pixel of the new frame already uses the new source.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clks with random inputs -> o_*=0, out_de=0, active_sel=0, switching=0, syncs inactive.
//  2 Latency: src 0 = 12'h5a3, in_de pulses 1 at cycle t -> o_{r,g,b}=5,a,3 exactly at t+2; h_sync/v_sync track their inputs with the same 2-cycle delay.
//  3 Switch (BLANK_FRAMES=1): select 0->2 mid-frame -> switching=1, source 0 shown to end of frame, one frame of black, then source 2; active_sel=2 from the second fb.
//  4 Cancel: src_sel 0->1->0 before fb -> switching returns to 0, no black frame, output unchanged.
//  5 Invalid: src_sel=7 with N_SRC=4, BLANK_FRAMES=0 -> from next fb o_*=f,f,f in the visible area and 0 in blanking.
//  6 Mid-switch reset: rst_n=0 during BLANK -> next cycle state RUN, active_sel=0, switching=0, outputs 0.

Source files
------------

// File: rtl/vga_source_mux.sv
// Pixel-source selector feeding the VGA output stage. Source changes are deferred to a
// frame boundary (optionally through blanked frames) so that no frame is ever torn.
module vga_source_mux #(
  parameter int               N_SRC        = 4,
  parameter int               CW           = 4,
  parameter int               SEL_W        = 3,
  parameter int               BLANK_FRAMES = 1,
  parameter logic [3*CW-1:0]  FILL_INVALID = {3*CW{1'b1}},
  parameter int               VS_ACT_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [N_SRC*3*CW-1:0] src_rgb,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_de,
  output logic [CW-1:0]         o_r,
  output logic [CW-1:0]         o_g,
  output logic [CW-1:0]         o_b,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  out_de,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  switching
);

  localparam int         PW        = 3 * CW;
  localparam logic       SYNC_IDLE = (VS_ACT_LOW != 0);
  localparam logic [SEL_W:0] NSRC_W = (SEL_W + 1)'(N_SRC);
  localparam logic [3:0] FCNT_INIT = 4'(BLANK_FRAMES);

  typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] pend_sel, pend_n, active_n;
  logic [3:0]       fcnt, fcnt_n;
  logic             vs_prev, vs_act, fb;
  logic             hs_d1, vs_d1, de_d1;
  logic [PW-1:0]    pick, rgb1, rgb2;

  assign vs_act = (VS_ACT_LOW != 0) ? ~in_vsync : in_vsync;
  assign fb     = vs_act & ~vs_prev;

  // Selection state and frame-boundary edge detector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_sel   <= '0;
      active_sel <= '0;
      fcnt       <= '0;
      vs_prev    <= 1'b0;
    end else begin
      state      <= state_n;
      pend_sel   <= pend_n;
      active_sel <= active_n;
      fcnt       <= fcnt_n;
      vs_prev    <= vs_act;
    end
  end

  always_comb begin
    state_n  = state;
    pend_n   = pend_sel;
    active_n = active_sel;
    fcnt_n   = fcnt;
    unique case (state)
      RUN: begin
        if (src_sel != active_sel) begin
          pend_n  = src_sel;
          state_n = PEND;
        end
      end
      PEND: begin
        pend_n = src_sel;
        // A request that returns to the displayed source is dropped without effect.
        if (src_sel == active_sel) begin
          state_n = RUN;
        end else if (fb) begin
          if (BLANK_FRAMES == 0) begin
            active_n = pend_sel;
            state_n  = RUN;
          end else begin
            fcnt_n  = FCNT_INIT;
            state_n = BLANK;
          end
        end
      end
      BLANK: begin
        pend_n = src_sel;
        if (fb) begin
          if (fcnt == 4'd1) begin
            active_n = pend_sel;
            state_n  = RUN;
          end else begin
            fcnt_n = fcnt - 4'd1;
          end
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign switching = (state == PEND) || (state == BLANK);

  always_comb begin
    pick = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (active_sel == SEL_W'(k)) pick = src_rgb[k*PW +: PW];
    end
  end

  // Two-stage pixel pipeline; syncs and de travel alongside so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb1   <= '0;
      rgb2   <= '0;
      hs_d1  <= SYNC_IDLE;
      vs_d1  <= SYNC_IDLE;
      de_d1  <= 1'b0;
      h_sync <= SYNC_IDLE;
      v_sync <= SYNC_IDLE;
      out_de <= 1'b0;
    end else begin
      if (state == BLANK)                 rgb1 <= '0;
      else if ({1'b0, active_sel} >= NSRC_W) rgb1 <= FILL_INVALID;
      else                                rgb1 <= pick;
      rgb2   <= de_d1 ? rgb1 : '0;
      hs_d1  <= in_hsync;
      vs_d1  <= in_vsync;
      de_d1  <= in_de;
      h_sync <= hs_d1;
      v_sync <= vs_d1;
      out_de <= de_d1;
    end
  end

  assign o_r = rgb2[3*CW-1:2*CW];
  assign o_g = rgb2[2*CW-1:CW];
  assign o_b = rgb2[CW-1:0];

endmodule

// File: tb/tb_vga_source_mux.sv
// Directed self-checking bench for vga_source_mux: one instance with one blank frame per
// switch, a second with immediate switching for the invalid-source case.
module tb_vga_source_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_sel, sel_b;
  logic [47:0] src_rgb;
  logic        in_hsync, in_vsync, in_de;

  logic [3:0]  o_r, o_g, o_b, o_r_b, o_g_b, o_b_b;
  logic        h_sync, v_sync, out_de, h_sync_b, v_sync_b, out_de_b;
  logic [2:0]  active_sel, active_sel_b;
  logic        switching, switching_b;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  vga_source_mux #(.BLANK_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .src_rgb(src_rgb),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .h_sync(h_sync), .v_sync(v_sync),
    .out_de(out_de), .active_sel(active_sel), .switching(switching)
  );

  vga_source_mux #(.BLANK_FRAMES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .src_sel(sel_b), .src_rgb(src_rgb),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .o_r(o_r_b), .o_g(o_g_b), .o_b(o_b_b), .h_sync(h_sync_b), .v_sync(v_sync_b),
    .out_de(out_de_b), .active_sel(active_sel_b), .switching(switching_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic de, input logic hs, input logic vs);
    src_sel  = sel;
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
  endtask

  // One-cycle active-low vsync pulse in blanking, then back to idle.
  task automatic frameBoundary();
    in_de    = 1'b0;
    in_vsync = 1'b0;
    tick();
    in_vsync = 1'b1;
    tick();
  endtask

  initial begin
    src_rgb = {12'h3e9, 12'h2c7, 12'h111, 12'h5a3};
    sel_b   = 3'd0;
    rst_n   = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    checkOutput("reset_rgb", {o_r, o_g, o_b}, 12'h000);
    checkOutput("reset_de", out_de, 1'b0);
    checkOutput("reset_active", active_sel, 3'd0);
    checkOutput("reset_switching", switching, 1'b0);
    checkOutput("reset_syncs", {h_sync, v_sync}, 2'b11);

    rst_n = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b1);
    tick(3);

    // Latency: one de/hsync pulse appears exactly two cycles later
    applyStimulus(3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lat_t1_de", out_de, 1'b0);
    checkOutput("lat_t1_hs", h_sync, 1'b1);
    tick();
    checkOutput("lat_t2_rgb", {o_r, o_g, o_b}, 12'h5a3);
    checkOutput("lat_t2_de", out_de, 1'b1);
    checkOutput("lat_t2_hs", h_sync, 1'b0);
    tick();
    checkOutput("lat_t3_rgb", {o_r, o_g, o_b}, 12'h000);
    checkOutput("lat_t3_hs", h_sync, 1'b1);

    applyStimulus(3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("vs_t1", v_sync, 1'b1);
    tick();
    checkOutput("vs_t2", v_sync, 1'b0);
    tick();
    checkOutput("vs_t3", v_sync, 1'b1);

    // Switch 0 -> 2 with one blank frame
    applyStimulus(3'd2, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("sw_pending", switching, 1'b1);
    tick(2);
    checkOutput("sw_old_frame_rgb", {o_r, o_g, o_b}, 12'h5a3);
    checkOutput("sw_old_active", active_sel, 3'd0);
    frameBoundary();
    checkOutput("sw_blank_switching", switching, 1'b1);
    in_de = 1'b1;
    tick(3);
    checkOutput("sw_blank_rgb", {o_r, o_g, o_b}, 12'h000);
    checkOutput("sw_blank_de", out_de, 1'b1);
    checkOutput("sw_blank_active", active_sel, 3'd0);
    in_de    = 1'b0;
    in_vsync = 1'b0;
    tick();
    checkOutput("sw_done_active", active_sel, 3'd2);
    checkOutput("sw_done_switching", switching, 1'b0);
    in_vsync = 1'b1;
    in_de    = 1'b1;
    tick(3);
    checkOutput("sw_new_rgb", {o_r, o_g, o_b}, 12'h2c7);

    // Cancel: 2 -> 1 -> 2 before any frame boundary
    applyStimulus(3'd1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("cancel_pending", switching, 1'b1);
    src_sel = 3'd2;
    tick();
    checkOutput("cancel_back", switching, 1'b0);
    frameBoundary();
    in_de = 1'b1;
    tick(3);
    checkOutput("cancel_rgb", {o_r, o_g, o_b}, 12'h2c7);
    checkOutput("cancel_active", active_sel, 3'd2);

    // Invalid index on the immediate-switch instance
    checkOutput("inv_before_rgb", {o_r_b, o_g_b, o_b_b}, 12'h5a3);
    sel_b = 3'd7;
    tick();
    checkOutput("inv_pending", switching_b, 1'b1);
    frameBoundary();
    checkOutput("inv_active", active_sel_b, 3'd7);
    checkOutput("inv_switching", switching_b, 1'b0);
    in_de = 1'b1;
    tick(3);
    checkOutput("inv_visible_rgb", {o_r_b, o_g_b, o_b_b}, 12'hfff);
    in_de = 1'b0;
    tick(2);
    checkOutput("inv_blank_rgb", {o_r_b, o_g_b, o_b_b}, 12'h000);
    checkOutput("inv_blank_de", out_de_b, 1'b0);

    // Reset during BLANK abandons the switch
    applyStimulus(3'd3, 1'b0, 1'b1, 1'b1);
    tick();
    frameBoundary();
    checkOutput("mrst_in_blank", switching, 1'b1);
    in_de = 1'b1;
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_switching", switching, 1'b0);
    checkOutput("mrst_active", active_sel, 3'd0);
    checkOutput("mrst_rgb", {o_r, o_g, o_b}, 12'h000);
    checkOutput("mrst_de", out_de, 1'b0);
    rst_n = 1'b1;
    tick(3);
    checkOutput("mrst_run_rgb", {o_r, o_g, o_b}, 12'h5a3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
